soc_system_nios_tx_fifo: RTL and testbench
==========================================

# soc_system_nios_tx_fifo

Avalon-MM write-side FIFO that lets the Nios/HPS master queue 32-bit words for a streaming consumer in the fabric. It is the producer end of the not-empty handshake: it drives the `not_empty` level that the Nios-side input PIO samples, and it presents queued words on a valid/ready output port. It sits on the same Avalon slave fabric as the other `soc_system` PIOs, with a 2-bit word address and registered readdata.

## Interface
- `DATA_WIDTH`, default 32: width of the queued word and of `out_data`.
- `DEPTH`, default 16: FIFO depth in words. Must be a power of 2, between 2 and 256.
- `AW`, default 4: log2(`DEPTH`).
- `clk`, input, 1: the single clock for the block.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `address`, input, 2: Avalon word address.
- `chipselect`, input, 1: slave select.
- `write_n`, input, 1: active-low write strobe.
- `writedata`, input, 32: write data.
- `readdata`, output, 32: registered read data.
- `out_data`, output, `DATA_WIDTH`: word at the FIFO head (show-ahead).
- `out_valid`, output, 1: head word is valid.
- `out_ready`, input, 1: consumer accepts the head word.
- `not_empty`, output, 1: level output to the Nios input PIO.
- `irq`, output, 1: level interrupt. Asserted when overflow is set and `irq_en` is 1.

## Operation
**Register map**
- Address 0, DATA:
  - A write pushes `writedata[DATA_WIDTH-1:0]`.
  - A read returns 0.
- Address 1, STATUS (read-only):
  - `[8:0]` = count.
  - `[16]` = empty.
  - `[17]` = full.
  - `[18]` = overflow (sticky).
  - All other bits read 0.
- Address 2, CONTROL (write):
  - bit0 = 1: flush.
  - bit1 = 1: clear overflow.
  - bit2: `irq_en` (stored).
  - Reading address 2 returns `{29'b0, irq_en, 2'b00}`.
- Address 3: reserved. Writes are ignored; reads return 0.

**Data path**
- Write strobe `wr = chipselect & ~write_n`.
- Push condition: `wr && address==0 && count<DEPTH`.
  - A push writes `mem[wr_ptr]` and advances `wr_ptr` modulo `DEPTH`.
  - A DATA write while count==DEPTH is dropped, sets overflow, and leaves the FIFO unchanged.
  - A write rejected for fullness is rejected even if a pop happens in the same cycle.
- Pop condition: `out_valid && out_ready`. A pop advances `rd_ptr` modulo `DEPTH`.
- Count is `AW+1` bits wide.
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged.
- Flush (CONTROL bit0 written as 1):
  - `wr_ptr`, `rd_ptr` and count go to 0 at the next edge.
  - Flush has priority over any push or pop in the same cycle.
  - The overflow bit and `irq_en` are unaffected by flush.
- Overflow clear: CONTROL bit1 clears overflow. If a clear and an overflowing write coincide, the set wins.
- Output derivation:
  - `out_valid = not_empty = (count != 0)`, decoded from registered count with no extra latency.
  - `out_data = mem[rd_ptr]`. It is undefined while `out_valid` = 0.
- The memory array needs no reset. All other state resets.

## Timing
- Reset values:
  - `readdata` = 0, `out_valid` = 0, `not_empty` = 0, `irq` = 0.
  - count = 0, pointers = 0, overflow = 0, `irq_en` = 0.
- `readdata` is registered every cycle, independent of read strobes: `readdata <= mux(address)`. Data for an address appears one edge after the address is presented; the fabric uses 1 wait-state-free cycle of read latency.
- Push to visibility:
  - A DATA write at edge N gives count, `not_empty`, `out_valid` and `out_data` updated after edge N.
  - The new count is visible on `readdata` after edge N+1 if STATUS is addressed.
- Pop: `out_data` shows the next word after the popping edge. Back-to-back pops at one word per cycle are supported.
- Empty FIFO: `out_valid` = 0. `out_ready` is ignored and no underflow occurs.
- Wrap-around: pointers roll from `DEPTH-1` to 0 with no gap.
- Reset mid-operation:
  - All queued words are discarded immediately (asynchronous).
  - `out_valid` drops in the same cycle.

## Test plan
- **Reset and idle.** Assert `reset_n`=0 mid-stream with 5 words queued → `out_valid`=0, `not_empty`=0, `readdata`=0 immediately; after release, STATUS reads 0x0001_0000.
- **Single word.** Write 0xDEAD_BEEF to address 0 with `out_ready`=0 → `not_empty`=1 and `out_data`=0xDEADBEEF after the edge; STATUS reads 0x0000_0001. Raise `out_ready` for 1 cycle → `out_valid`=0.
- **Fill and overflow.** Write 17 words 1..17 with `out_ready`=0 → STATUS = 0x0006_0010 (full, overflow, count 16). Drain 16 words → order 1..16 and 17 absent. `irq` = 1 only after CONTROL = 0x4; CONTROL = 0x6 clears `irq`.
- **Simultaneous push and pop at count 8.** Hold `out_ready`=1 and write every cycle for 20 cycles → count stays 8, output order is preserved across pointer wrap. With count=16, a write plus a pop in the same cycle → the write is dropped, overflow = 1, count = 15.
- **Flush collision.** Queue 3 words, then write CONTROL = 0x1 in the same cycle as `out_ready`=1 → count = 0 and `out_valid` = 0 next cycle; overflow is unchanged.
- **Stream throughput.** Queue 16 words, then hold `out_ready`=1 → 16 consecutive valid cycles, then `not_empty` falls exactly after the 16th popping edge.

Source files
------------

// File: rtl/soc_system_nios_tx_fifo.sv
// soc_system_nios_tx_fifo
// Avalon-MM write-side FIFO. The Nios/HPS master pushes words through the
// DATA register. A streaming consumer in the fabric drains them from a
// show-ahead valid/ready port. The not_empty level feeds the Nios-side input
// PIO.
//
// Ports
//   clk, reset_n         : clock, asynchronous active-low reset
//   address[1:0]         : word address (0 DATA, 1 STATUS, 2 CONTROL, 3 rsvd)
//   chipselect, write_n  : slave select, active-low write strobe
//   writedata[31:0]      : write data
//   readdata[31:0]       : read data, registered every cycle from address
//   out_data, out_valid  : head word (show-ahead) and its valid flag
//   out_ready            : consumer accepts the head word
//   not_empty            : level copy of out_valid for the input PIO
//   irq                  : overflow interrupt, gated by irq_en
module soc_system_nios_tx_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  not_empty,
  output logic                  irq
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [AW:0]           count_r;
  logic                  overflow_r;
  logic                  irq_en_r;
  logic [31:0]           readdata_r;

  logic        wr_s;
  logic        full_s;
  logic        empty_s;
  logic        push_s;
  logic        pop_s;
  logic        ovf_set_s;
  logic        ctrl_wr_s;
  logic        flush_s;
  logic        ovf_clr_s;
  logic [8:0]  count9_s;
  logic [31:0] rd_mux_s;

  assign wr_s      = chipselect & ~write_n;
  assign full_s    = (count_r == FULL_COUNT);
  assign empty_s   = (count_r == {(AW+1){1'b0}});
  // Fullness is judged on the pre-edge count, so a same-cycle pop never
  // rescues a write that arrives while the FIFO is full.
  assign push_s    = wr_s & (address == 2'd0) & ~full_s;
  assign ovf_set_s = wr_s & (address == 2'd0) & full_s;
  assign ctrl_wr_s = wr_s & (address == 2'd2);
  assign flush_s   = ctrl_wr_s & writedata[0];
  assign ovf_clr_s = ctrl_wr_s & writedata[1];
  assign pop_s     = out_valid & out_ready;
  assign count9_s  = 9'(count_r);

  assign out_valid = ~empty_s;
  assign not_empty = ~empty_s;
  assign out_data  = mem[rd_ptr_r];
  assign irq       = overflow_r & irq_en_r;
  assign readdata  = readdata_r;

  // Storage array: written on push only, no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_r] <= writedata[DATA_WIDTH-1:0];
    end
  end

  // Pointers and occupancy; flush overrides any push/pop in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush_s) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow (set beats clear) and the stored interrupt enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
      irq_en_r   <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr_s) begin
        overflow_r <= 1'b0;
      end
      if (ctrl_wr_s) begin
        irq_en_r <= writedata[2];
      end
    end
  end

  // Read mux, decoded from the current address without any read strobe.
  always_comb begin
    rd_mux_s = 32'd0;
    case (address)
      2'd0:    rd_mux_s = 32'd0;
      2'd1:    rd_mux_s = {13'd0, overflow_r, full_s, empty_s, 7'd0, count9_s};
      2'd2:    rd_mux_s = {29'd0, irq_en_r, 2'b00};
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Registered read data: one cycle of read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 32'd0;
    end else begin
      readdata_r <= rd_mux_s;
    end
  end

endmodule

// File: tb/tb_soc_system_nios_tx_fifo.sv
module tb_soc_system_nios_tx_fifo;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        not_empty;
  logic        irq;

  int total;
  int bad;

  // Reference model state.
  logic [31:0] q[$];
  logic        m_ovf;
  logic        m_irq_en;

  soc_system_nios_tx_fifo dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .not_empty  (not_empty),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int n;
    n = q.size();
    return {13'd0, m_ovf, (n == 16), (n == 0), 7'd0, 9'(n)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus/consumer cycle: optional write plus optional out_ready.
  task automatic cyc(input bit w, input logic [1:0] a, input logic [31:0] d, input bit rdy);
    int n;
    n = q.size();
    address    = a;
    chipselect = w;
    write_n    = ~w;
    writedata  = d;
    out_ready  = rdy;
    #1;
    chk("valid", {31'd0, out_valid}, {31'd0, (n != 0)});
    if (rdy && n != 0) begin
      chk("data", out_data, q.pop_front());
    end
    if (w && a == 2'd0) begin
      if (n < 16) q.push_back(d);
      else m_ovf = 1'b1;
    end
    if (w && a == 2'd2) begin
      if (d[0]) q.delete();
      if (d[1]) m_ovf = 1'b0;
      m_irq_en = d[2];
    end
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    out_ready  = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address    = a;
    chipselect = 1'b0;
    write_n    = 1'b1;
    out_ready  = 1'b0;
    tick();
    v = readdata;
  endtask

  initial begin
    logic [31:0] v;
    total = 0; bad = 0;
    m_ovf = 1'b0; m_irq_en = 1'b0;
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'd0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_not_empty", {31'd0, not_empty}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    tick();
    rd(2'd1, v);
    chk("idle_status", v, 32'h0001_0000);

    // Single word.
    cyc(1'b1, 2'd0, 32'hDEAD_BEEF, 1'b0);
    chk("single_ne", {31'd0, not_empty}, 32'd1);
    chk("single_data", out_data, 32'hDEAD_BEEF);
    rd(2'd1, v);
    chk("single_status", v, 32'h0000_0001);
    cyc(1'b0, 2'd0, 32'd0, 1'b1);
    chk("single_drained", {31'd0, out_valid}, 32'd0);

    // Fill and overflow.
    for (int i = 1; i <= 17; i++) cyc(1'b1, 2'd0, 32'(i), 1'b0);
    rd(2'd1, v);
    chk("full_status", v, 32'h0006_0010);
    chk("irq_disabled", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 2'd0, 32'd0, 1'b1);
    chk("drained_valid", {31'd0, out_valid}, 32'd0);
    cyc(1'b1, 2'd2, 32'h4, 1'b0);
    chk("irq_on", {31'd0, irq}, 32'd1);
    rd(2'd2, v);
    chk("ctrl_read", v, 32'h4);
    cyc(1'b1, 2'd2, 32'h6, 1'b0);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    rd(2'd1, v);
    chk("ovf_cleared", v, exp_status());

    // Simultaneous push/pop at count 8, across pointer wrap.
    for (int i = 0; i < 8; i++) cyc(1'b1, 2'd0, 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 2'd0, 32'h200 + 32'(i), 1'b1);
    rd(2'd1, v);
    chk("steady_count8", v, 32'h0000_0008);
    for (int i = 0; i < 8; i++) cyc(1'b1, 2'd0, 32'h300 + 32'(i), 1'b0);
    cyc(1'b1, 2'd0, 32'h0000_0BAD, 1'b1);
    rd(2'd1, v);
    chk("full_pushpop_status", v, 32'h0004_000F);
    chk("full_pushpop_model", v, exp_status());
    chk("irq_ovf", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 15; i++) cyc(1'b0, 2'd0, 32'd0, 1'b1);

    // Flush collision with a pop; overflow stays set.
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'd0, 32'h400 + 32'(i), 1'b0);
    cyc(1'b1, 2'd2, 32'h1, 1'b1);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    rd(2'd1, v);
    chk("flush_status", v, 32'h0005_0000);
    chk("flush_irq", {31'd0, irq}, {31'd0, m_ovf & m_irq_en});
    cyc(1'b1, 2'd2, 32'h2, 1'b0);

    // Reserved address and DATA read.
    cyc(1'b1, 2'd3, 32'hFFFF_FFFF, 1'b0);
    rd(2'd3, v);
    chk("rsvd_read", v, 32'd0);
    rd(2'd1, v);
    chk("rsvd_status", v, exp_status());

    // Stream throughput.
    for (int i = 0; i < 16; i++) cyc(1'b1, 2'd0, 32'h500 + 32'(i), 1'b0);
    rd(2'd0, v);
    chk("data_read", v, 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("stream_ne", {31'd0, not_empty}, 32'd1);
      cyc(1'b0, 2'd0, 32'd0, 1'b1);
    end
    chk("stream_end_ne", {31'd0, not_empty}, 32'd0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'd0, 32'h600 + 32'(i), 1'b0);
    address = 2'd1;
    tick();
    chk("pre_rst_status", readdata, 32'h0000_0005);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_ne", {31'd0, not_empty}, 32'd0);
    chk("arst_readdata", readdata, 32'd0);
    q.delete(); m_ovf = 1'b0; m_irq_en = 1'b0;
    tick();
    #2 reset_n = 1'b1;
    tick();
    rd(2'd1, v);
    chk("post_rst_status", v, 32'h0001_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
